// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with blanking gap,
// leading-zero suppression and frame-aligned double buffering of the displayed time.
module display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      lzb_en,
    output logic [3:0]                bcd_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     anode_n,
    output logic                      frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    typedef enum logic {PH_BLANK, PH_DRIVE} phase_e;

    localparam phase_e PH_RESET = (BLANK_CYCLES != 0) ? PH_BLANK : PH_DRIVE;

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    phase_e                           phase_q, phase_d;
    logic [NUM_DIGITS-1:0][3:0]       disp_q, disp_d;
    logic [NUM_DIGITS-1:0]            dpb_q, dpb_d;
    logic [NUM_DIGITS-1:0][3:0]       pend_q, pend_d;
    logic [NUM_DIGITS-1:0]            pdp_q, pdp_d;
    logic                             flag_q, flag_d;
    logic [NUM_DIGITS-1:0]            anode_q, anode_d;
    logic [3:0]                       bcd_q, bcd_d;
    logic                             dpo_q, dpo_d;
    logic                             fd_q, fd_d;
    logic [NUM_DIGITS-1:0]            lz;
    logic                             wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= PH_RESET;
            disp_q  <= '1;
            dpb_q   <= '0;
            pend_q  <= '0;
            pdp_q   <= '0;
            flag_q  <= 1'b0;
            anode_q <= '1;
            bcd_q   <= 4'hF;
            dpo_q   <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            disp_q  <= disp_d;
            dpb_q   <= dpb_d;
            pend_q  <= pend_d;
            pdp_q   <= pdp_d;
            flag_q  <= flag_d;
            anode_q <= anode_d;
            bcd_q   <= bcd_d;
            dpo_q   <= dpo_d;
            fd_q    <= fd_d;
        end
    end

    // Slot counter, digit index and the pending/display buffer pair.
    always_comb begin
        wrap   = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
        cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        idx_d  = idx_q;
        disp_d = disp_q;
        dpb_d  = dpb_q;
        pend_d = pend_q;
        pdp_d  = pdp_q;
        flag_d = flag_q;
        if (cnt_q == CNT_MAX) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        if (load) begin
            pend_d = digits_in;
            pdp_d  = dp_in;
            flag_d = 1'b1;
        end
        // A load coinciding with the wrap bypasses pending and lands on the same edge.
        if (wrap) begin
            flag_d = 1'b0;
            if (load) begin
                disp_d = digits_in;
                dpb_d  = dp_in;
            end else if (flag_q) begin
                disp_d = pend_q;
                dpb_d  = pdp_q;
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_BLANK: if (cnt_d == BLANK_END) phase_d = PH_DRIVE;
            PH_DRIVE: if ((cnt_d == '0) && (BLANK_END != '0)) phase_d = PH_BLANK;
            default:  phase_d = PH_RESET;
        endcase
    end

    // lz[i]: every digit from position i up to the most significant one is zero.
    always_comb begin
        lz = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if ((k >= i) && (disp_d[k] != 4'h0)) lz[i] = 1'b0;
            end
        end
    end

    always_comb begin
        anode_d = '1;
        bcd_d   = 4'hF;
        dpo_d   = 1'b1;
        fd_d    = (cnt_d == '0) && (idx_d == '0);
        if ((phase_d == PH_DRIVE) && !(lzb_en && (idx_d != '0) && lz[idx_d])) begin
            anode_d[idx_d] = 1'b0;
            bcd_d          = disp_d[idx_d];
            dpo_d          = ~dpb_d[idx_d];
        end
    end

    assign anode_n    = anode_q;
    assign bcd_out    = bcd_q;
    assign dp_out     = dpo_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner (4 digits, 8-cycle slots, 2 blank cycles): cycle-index
// reference model feeding a scoreboard, plus table-driven per-frame checks.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic        lzb_en = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  bcd_out;
    logic [3:0]  anode_n;
    logic        dp_out;
    logic        frame_done;

    display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .lzb_en     (lzb_en),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .anode_n    (anode_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       dp;
        logic       fd;
        int         n;
    } exp_t;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic        lzb;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_dpn;
        logic [3:0]  exp_on;
    } vec_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    logic [15:0] m_disp = 16'hFFFF;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_pdp = '0;
    logic        m_flag = 1'b0;
    vec_t        tbl[7];

    // Expected outputs for the cycle that is n cycles after reset release.
    function automatic exp_t model_out(int cyc);
        exp_t e;
        int   c;
        int   i;
        bit   z;
        c = cyc % 8;
        i = (cyc / 8) % 4;
        e.an  = 4'b1111;
        e.bcd = 4'hF;
        e.dp  = 1'b1;
        e.fd  = (cyc % 32 == 0);
        e.n   = cyc;
        z = 1'b1;
        for (int k = i; k < 4; k++) if (m_disp[k*4 +: 4] != 4'h0) z = 1'b0;
        if (c >= 2 && !(lzb_en && i > 0 && z)) begin
            e.an  = ~(4'b0001 << i);
            e.bcd = m_disp[i*4 +: 4];
            e.dp  = ~m_dp[i];
        end
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        if (n % 32 == 31) begin
            if (load) begin
                m_disp = digits_in;
                m_dp   = dp_in;
            end else if (m_flag) begin
                m_disp = m_pend;
                m_dp   = m_pdp;
            end
            m_flag = 1'b0;
        end else if (load) begin
            m_pend = digits_in;
            m_pdp  = dp_in;
            m_flag = 1'b1;
        end
        n++;
        e = model_out(n);
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({anode_n, bcd_out, dp_out, frame_done} !== {e.an, e.bcd, e.dp, e.fd}) begin
                errors++;
                $display("FAIL scoreboard n=%0d got an=%b bcd=%h dp=%b fd=%b want an=%b bcd=%h dp=%b fd=%b",
                         e.n, anode_n, bcd_out, dp_out, frame_done, e.an, e.bcd, e.dp, e.fd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s n=%0d got %0h want %0h", name, n, got, want);
        end
    endtask

    task automatic reset_cycle();
        q.delete();
        rst_n = 1'b0;
        #1;
        chk("reset_anode", 32'(anode_n), 32'hF);
        chk("reset_bcd", 32'(bcd_out), 32'hF);
        chk("reset_dp", 32'(dp_out), 32'h1);
        chk("reset_fd", 32'(frame_done), 32'h0);
        n      = 0;
        m_disp = 16'hFFFF;
        m_dp   = '0;
        m_pend = '0;
        m_pdp  = '0;
        m_flag = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic run_to(input int r);
        for (int k = 0; k < 32 && (n % 32) != r; k++) tick();
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    // Walks the next whole frame, checking each slot mid-way through its drive phase.
    task automatic check_frame(input string name, input vec_t v);
        logic [3:0] an_w;
        int         i;
        run_to(0);
        for (int k = 0; k < 32; k++) begin
            if (n % 8 == 4) begin
                i = (n / 8) % 4;
                an_w = v.exp_on[i] ? ~(4'b0001 << i) : 4'b1111;
                chk({name, "_anode"}, 32'(anode_n), 32'(an_w));
                chk({name, "_bcd"}, 32'(bcd_out), 32'(v.exp_bcd[i*4 +: 4]));
                chk({name, "_dp"}, 32'(dp_out), 32'(v.exp_dpn[i]));
            end
            tick();
        end
    endtask

    initial begin
        vec_t v;
        int   pulses;
        int   last;

        tbl[0] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b1111, 4'b1111};
        tbl[1] = '{16'h0005, 4'b0000, 1'b1, 16'hFFF5, 4'b1111, 4'b0001};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, 16'hFFF0, 4'b1111, 4'b0001};
        tbl[3] = '{16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b1111, 4'b1111};
        tbl[4] = '{16'h0C05, 4'b0100, 1'b1, 16'hFC05, 4'b1011, 4'b0111};
        tbl[5] = '{16'h0F00, 4'b0000, 1'b1, 16'hFF00, 4'b1111, 4'b0111};
        tbl[6] = '{16'h0012, 4'b1000, 1'b1, 16'hFF12, 4'b1111, 4'b0011};

        #1 reset_cycle();

        tick();
        chk("first_blank_anode", 32'(anode_n), 32'hF);
        tick();
        chk("first_drive_anode", 32'(anode_n), 32'hE);
        chk("first_drive_bcd", 32'(bcd_out), 32'hF);

        // Load mid-slot (digit 1, cnt 3); scoreboard confirms display holds until the wrap.
        for (int t = 0; t < 7; t++) begin
            lzb_en = tbl[t].lzb;
            run_to(11);
            load_word(tbl[t].dig, tbl[t].dp);
            check_frame($sformatf("tbl%0d", t), tbl[t]);
        end

        lzb_en = 1'b0;
        run_to(0);
        load_word(16'h1234, 4'b0100);
        check_frame("dp2", '{16'h1234, 4'b0100, 1'b0, 16'h1234, 4'b1011, 4'b1111});

        run_to(1);
        pulses = 0;
        last   = -1;
        for (int k = 0; k < 96; k++) begin
            tick();
            if (frame_done) begin
                pulses++;
                chk("fd_phase", 32'(n % 32), 32'h0);
                if (last >= 0) chk("fd_gap", 32'(n - last), 32'd32);
                last = n;
            end
        end
        chk("fd_count", 32'(pulses), 32'd3);

        run_to(31);
        load_word(16'h9876, 4'b0000);
        chk("wrap_load_n", 32'(n % 32), 32'h0);
        check_frame("wrapload", '{16'h9876, 4'b0000, 1'b0, 16'h9876, 4'b1111, 4'b1111});

        run_to(5);
        load_word(16'h4321, 4'b0001);
        run_to(20);
        load_word(16'h5678, 4'b0010);
        check_frame("lastwins", '{16'h5678, 4'b0010, 1'b0, 16'h5678, 4'b1101, 4'b1111});

        run_to(21);
        chk("pre_reset_anode", 32'(anode_n), 32'hB);
        #2 reset_cycle();
        v = '{16'hFFFF, 4'b0000, 1'b0, 16'hFFFF, 4'b1111, 4'b1111};
        check_frame("post_reset", v);
        check_frame("post_reset2", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
